// File: rtl/ber_test_controller.sv
// ---------------------------------------------------------------------------
// ber_test_controller
//
// Purpose:
//   Sequences a bit-error-rate test over a serial channel. A PRBS7 pattern is
//   transmitted, the channel latency is located by stepping a lag value until
//   LOCK_WINDOW consecutive received bits match the delayed transmit history,
//   and then injection is enabled (inject_stop low) while mismatches are
//   counted over a programmed number of bits. Results hold until the next
//   test starts.
//
// Ports:
//   clock         in   single clock, all state changes on posedge
//   reset         in   asynchronous active-low reset
//   start         in   begin a test (accepted in IDLE, DONE or FAIL)
//   abort         in   cancel a running test (FLUSH, SEARCH, CHECK)
//   sample_count  in   number of bits to check, latched on accepted start
//   rx_data       in   bit returned from the channel
//   rx_valid      in   rx_data is a valid 0/1 decode
//   tx_data       out  PRBS bit driven into the channel
//   inject_stop   out  1 = error injection suppressed
//   busy          out  high in FLUSH, SEARCH and CHECK
//   done          out  high in DONE
//   fail          out  high in FAIL (no alignment found)
//   locked        out  alignment found, held through DONE
//   lag           out  current / found channel latency in cycles
//   error_count   out  saturating mismatch count from CHECK
//   bits_count    out  number of bits compared in CHECK
// ---------------------------------------------------------------------------
module ber_test_controller #(
  parameter int MAX_LAG     = 15,
  parameter int LOCK_WINDOW = 64,
  parameter int COUNT_W     = 32,
  parameter int ERR_W       = 32,
  parameter int LAG_W       = $clog2(MAX_LAG + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] sample_count,
  input  logic               rx_data,
  input  logic               rx_valid,
  output logic               tx_data,
  output logic               inject_stop,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic               locked,
  output logic [LAG_W-1:0]   lag,
  output logic [ERR_W-1:0]   error_count,
  output logic [COUNT_W-1:0] bits_count
);

  localparam int         RUN_W     = $clog2(LOCK_WINDOW + 1);
  localparam logic [6:0] LFSR_SEED = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SEARCH,
    S_CHECK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t             state_q;
  logic [6:0]         lfsr_q;
  logic               tx_data_q;
  logic               inject_stop_q;
  logic               busy_q;
  logic               done_q;
  logic               fail_q;
  logic               locked_q;
  logic [LAG_W-1:0]   lag_q;
  logic [LAG_W-1:0]   flush_cnt_q;
  logic [RUN_W-1:0]   match_run_q;
  logic [ERR_W-1:0]   error_count_q;
  logic [COUNT_W-1:0] bits_count_q;
  logic [COUNT_W-1:0] sample_q;

  // past_q[k] holds the tx_data value driven k+1 cycles ago
  logic [MAX_LAG-1:0] past_q;

  logic [6:0]         lfsr_d;
  logic [MAX_LAG:0]   hist_d;
  logic               expected_bit;
  logic               mismatch;
  logic               running;
  logic               launch;
  logic               abort_hit;

  // Fibonacci PRBS7, x^7 + x^6 + 1: feedback from bits 6 and 5, shift left
  assign lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

  // hist_d[0] is the bit currently on tx_data, hist_d[k] the bit k cycles ago
  assign hist_d = {past_q, tx_data_q};

  always_comb begin
    expected_bit = hist_d[lag_q];
    mismatch     = !rx_valid || (rx_data != expected_bit);
  end

  assign running   = (state_q == S_FLUSH) || (state_q == S_SEARCH) ||
                     (state_q == S_CHECK);
  // abort outranks start whenever a test is running
  assign abort_hit = abort && running;
  assign launch    = start && !running;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      tx_data_q     <= 1'b0;
      inject_stop_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      locked_q      <= 1'b0;
      lag_q         <= '0;
      flush_cnt_q   <= '0;
      match_run_q   <= '0;
      error_count_q <= '0;
      bits_count_q  <= '0;
      sample_q      <= '0;
      past_q        <= '0;
    end else begin
      past_q <= hist_d[MAX_LAG-1:0];

      // The pattern keeps running in every state except IDLE
      if (state_q != S_IDLE) begin
        lfsr_q    <= lfsr_d;
        tx_data_q <= lfsr_d[6];
      end

      if (launch) begin
        state_q       <= S_FLUSH;
        lfsr_q        <= LFSR_SEED;
        tx_data_q     <= LFSR_SEED[6];
        inject_stop_q <= 1'b1;
        busy_q        <= 1'b1;
        done_q        <= 1'b0;
        fail_q        <= 1'b0;
        locked_q      <= 1'b0;
        lag_q         <= '0;
        flush_cnt_q   <= '0;
        match_run_q   <= '0;
        error_count_q <= '0;
        bits_count_q  <= '0;
        sample_q      <= sample_count;
      end else if (abort_hit) begin
        // Counts and lag stay frozen for inspection
        state_q       <= S_IDLE;
        tx_data_q     <= 1'b0;
        inject_stop_q <= 1'b1;
        busy_q        <= 1'b0;
        done_q        <= 1'b0;
        fail_q        <= 1'b0;
        locked_q      <= 1'b0;
      end else begin
        case (state_q)
          S_FLUSH: begin
            // MAX_LAG+1 cycles so the channel and history hold real pattern
            if (flush_cnt_q == LAG_W'(MAX_LAG)) begin
              state_q     <= S_SEARCH;
              lag_q       <= '0;
              match_run_q <= '0;
            end else begin
              flush_cnt_q <= flush_cnt_q + 1'b1;
            end
          end

          S_SEARCH: begin
            if (mismatch) begin
              match_run_q <= '0;
              if (lag_q == LAG_W'(MAX_LAG)) begin
                state_q  <= S_FAIL;
                busy_q   <= 1'b0;
                fail_q   <= 1'b1;
                locked_q <= 1'b0;
              end else begin
                lag_q <= lag_q + 1'b1;
              end
            end else if (match_run_q == RUN_W'(LOCK_WINDOW - 1)) begin
              // This match completes the window
              state_q       <= S_CHECK;
              locked_q      <= 1'b1;
              inject_stop_q <= 1'b0;
              match_run_q   <= '0;
            end else begin
              match_run_q <= match_run_q + 1'b1;
            end
          end

          S_CHECK: begin
            if (bits_count_q < sample_q) begin
              bits_count_q <= bits_count_q + 1'b1;
              if (mismatch && (error_count_q != {ERR_W{1'b1}})) begin
                error_count_q <= error_count_q + 1'b1;
              end
            end else begin
              state_q       <= S_DONE;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
              inject_stop_q <= 1'b1;
            end
          end

          default: begin
            // IDLE, DONE and FAIL hold until an accepted start
          end
        endcase
      end
    end
  end

  assign tx_data     = tx_data_q;
  assign inject_stop = inject_stop_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign locked      = locked_q;
  assign lag         = lag_q;
  assign error_count = error_count_q;
  assign bits_count  = bits_count_q;

endmodule

// File: tb/tb_ber_test_controller.sv
module tb_ber_test_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] sample_count = '0;
  logic        rx_data;
  logic        rx_valid;

  logic        tx_data, inject_stop, busy, done, fail, locked;
  logic [3:0]  lag;
  logic [31:0] error_count, bits_count;

  logic        tx_data4, inject_stop4, busy4, done4, fail4, locked4;
  logic [3:0]  lag4;
  logic [3:0]  error_count4;
  logic [31:0] bits_count4;

  int          checks = 0;
  int          errors = 0;

  // Channel model: programmable delay, optional bit inversion and invalid flag
  int          delay_sel = 0;
  logic        inv_bit   = 1'b0;
  logic        valid_bit = 1'b1;
  logic [31:0] dly = '0;

  always #5 clock = ~clock;

  always @(posedge clock) dly <= {dly[30:0], tx_data};

  always_comb begin
    rx_data  = ((delay_sel == 0) ? tx_data : dly[delay_sel-1]) ^ inv_bit;
    rx_valid = valid_bit;
  end

  ber_test_controller dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .sample_count(sample_count), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .inject_stop(inject_stop), .busy(busy), .done(done),
    .fail(fail), .locked(locked), .lag(lag), .error_count(error_count),
    .bits_count(bits_count)
  );

  // Narrow error counter copy, fed identically, to exercise saturation
  ber_test_controller #(.ERR_W(4)) dut4 (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .sample_count(sample_count), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data4), .inject_stop(inject_stop4), .busy(busy4), .done(done4),
    .fail(fail4), .locked(locked4), .lag(lag4), .error_count(error_count4),
    .bits_count(bits_count4)
  );

  typedef struct {
    int delay;
    int sc;
    int n_inv;
    int n_inval;
    bit inv_all;
    int exp_lag;
    int exp_locked;
    int exp_done;
    int exp_fail;
    int exp_err;
    int exp_err4;
    int exp_bits;
    int exp_chk;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input int sc);
    @(negedge clock);
    start        = 1'b1;
    sample_count = 32'(sc);
    @(negedge clock);
    start        = 1'b0;
  endtask

  // Runs one test and compares the final state against the record
  task automatic run_vec(input vec_t v, input int idx);
    int  chk;
    bit  finished;
    delay_sel = v.delay;
    inv_bit   = 1'b0;
    valid_bit = 1'b1;
    do_start(v.sc);
    chk      = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (done || fail) begin
        finished = 1'b1;
        break;
      end
      if (!inject_stop) begin
        check("check_busy", 64'(busy), 64'd1);
        inv_bit   = v.inv_all || ((chk % 3 == 2) && (chk / 3 < v.n_inv));
        valid_bit = !((chk % 10 == 1) && (chk / 10 < v.n_inval));
        chk++;
      end else begin
        inv_bit   = 1'b0;
        valid_bit = 1'b1;
      end
      @(negedge clock);
    end
    inv_bit   = 1'b0;
    valid_bit = 1'b1;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL timeout vec %0d: got no done/fail expected done or fail", idx);
    end
    check("lag",         64'(lag),          64'(v.exp_lag));
    check("locked",      64'(locked),       64'(v.exp_locked));
    check("done",        64'(done),         64'(v.exp_done));
    check("fail",        64'(fail),         64'(v.exp_fail));
    check("busy_end",    64'(busy),         64'd0);
    check("inject_stop", 64'(inject_stop),  64'd1);
    check("error_count", 64'(error_count),  64'(v.exp_err));
    check("error_count4",64'(error_count4), 64'(v.exp_err4));
    check("bits_count",  64'(bits_count),   64'(v.exp_bits));
    check("check_cycles",64'(chk),          64'(v.exp_chk));
    $display("vec %0d: delay=%0d sc=%0d lag=%0d locked=%0d done=%0d fail=%0d err=%0d err4=%0d bits=%0d chk=%0d",
             idx, v.delay, v.sc, lag, locked, done, fail, error_count, error_count4,
             bits_count, chk);
  endtask

  initial begin
    int   exp_tx[14];
    int   b_before;
    bit   got_lock;
    vec_t clean;

    //           delay  sc  inv inval all lag lk dn fl err err4 bits chk
    vecs[0] = '{0,   1000,  0,  0,  0,  0,  1, 1, 0,  0,  0, 1000, 1001};
    vecs[1] = '{5,    200,  0,  0,  0,  5,  1, 1, 0,  0,  0,  200,  201};
    vecs[2] = '{5,    300,  7,  0,  0,  5,  1, 1, 0,  7,  7,  300,  301};
    vecs[3] = '{20,   100,  0,  0,  0, 15,  0, 0, 1,  0,  0,    0,    0};
    vecs[4] = '{3,     50,  0,  3,  0,  3,  1, 1, 0,  3,  3,   50,   51};
    vecs[5] = '{2,     40,  0,  0,  1,  2,  1, 1, 0, 40, 15,   40,   41};
    vecs[6] = '{0,      0,  0,  0,  0,  0,  1, 1, 0,  0,  0,    0,    1};

    // PRBS7 from seed 7F: seven ones, then 0 until bit 6 refills at step 13
    exp_tx = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_tx",          64'(tx_data),     64'd0);
    check("rst_inject_stop", 64'(inject_stop), 64'd1);
    check("rst_busy",        64'(busy),        64'd0);
    check("rst_done",        64'(done),        64'd0);
    check("rst_fail",        64'(fail),        64'd0);
    check("rst_locked",      64'(locked),      64'd0);
    check("rst_lag",         64'(lag),         64'd0);
    check("rst_err",         64'(error_count), 64'd0);
    check("rst_bits",        64'(bits_count),  64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Zero-latency timing: first PRBS bits, lock 80 edges after start
    delay_sel = 0;
    do_start(10);
    for (int k = 0; k <= 80; k++) begin
      if (k == 0) check("start_busy", 64'(busy), 64'd1);
      if (k < 14 && (k == 0 || k == 6 || k == 7 || k == 12 || k == 13))
        check("prbs_bit", 64'(tx_data), 64'(exp_tx[k]));
      if (k == 79) begin
        check("pre_lock_locked", 64'(locked),      64'd0);
        check("pre_lock_inject", 64'(inject_stop), 64'd1);
      end
      if (k == 80) begin
        check("lock_locked", 64'(locked),      64'd1);
        check("lock_inject", 64'(inject_stop), 64'd0);
        check("lock_busy",   64'(busy),        64'd1);
      end
      if (k < 80) @(negedge clock);
    end
    for (int cyc = 0; cyc < 100 && !done; cyc++) @(negedge clock);
    check("timing_done", 64'(done),       64'd1);
    check("timing_bits", 64'(bits_count), 64'd10);
    $display("timing run: lag=%0d bits=%0d err=%0d", lag, bits_count, error_count);

    // Table-driven tests
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Abort mid-CHECK, with start asserted in the same cycle
    delay_sel = 0;
    do_start(1000);
    got_lock = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (locked) begin
        got_lock = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("abort_got_lock", 64'(got_lock), 64'd1);
    repeat (100) @(negedge clock);
    b_before = int'(bits_count);
    check("abort_bits_before", 64'(b_before), 64'd100);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy",   64'(busy),        64'd0);
    check("abort_inject", 64'(inject_stop), 64'd1);
    check("abort_locked", 64'(locked),      64'd0);
    check("abort_done",   64'(done),        64'd0);
    check("abort_fail",   64'(fail),        64'd0);
    check("abort_bits",   64'(bits_count),  64'd100);
    check("abort_tx",     64'(tx_data),     64'd0);
    @(negedge clock);
    check("abort_bits_hold", 64'(bits_count), 64'd100);
    check("abort_idle_busy", 64'(busy),       64'd0);
    $display("abort: bits frozen at %0d", bits_count);
    clean = '{0, 120, 0, 0, 0, 0, 1, 1, 0, 0, 0, 120, 121};
    run_vec(clean, 7);

    // Reset mid-SEARCH
    delay_sel = 5;
    do_start(100);
    repeat (20) @(negedge clock);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx",     64'(tx_data),     64'd0);
    check("mid_rst_inject", 64'(inject_stop), 64'd1);
    check("mid_rst_busy",   64'(busy),        64'd0);
    check("mid_rst_done",   64'(done),        64'd0);
    check("mid_rst_fail",   64'(fail),        64'd0);
    check("mid_rst_locked", 64'(locked),      64'd0);
    check("mid_rst_lag",    64'(lag),         64'd0);
    check("mid_rst_err",    64'(error_count), 64'd0);
    check("mid_rst_bits",   64'(bits_count),  64'd0);
    $display("reset mid-SEARCH: busy=%0d lag=%0d", busy, lag);
    @(negedge clock);
    reset = 1'b1;
    clean = '{5, 80, 0, 0, 0, 5, 1, 1, 0, 0, 0, 80, 81};
    run_vec(clean, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
